// File: rtl/jump_cache.sv
// Direct-mapped branch target cache with 2-bit hysteresis counters.
// Zero-latency lookup on current_pc; training and statistics on negedge clock.
module jump_cache #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] current_pc,
  output logic        do_jcache,
  output logic [31:0] jcache_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        invalidate,
  output logic [15:0] stat_hits
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]  valid;
  logic [TAG_BITS-1:0] tag    [ENTRIES];
  logic [31:0]         target [ENTRIES];
  logic [1:0]          ctr    [ENTRIES];

  logic [INDEX_BITS-1:0] lidx;
  logic [INDEX_BITS-1:0] uidx;
  logic [TAG_BITS-1:0]   ltag;
  logic [TAG_BITS-1:0]   utag;
  logic                  hit;
  logic                  umatch;
  logic                  unused_bits;

  assign lidx = current_pc[INDEX_BITS+1:2];
  assign ltag = current_pc[31:INDEX_BITS+2];
  assign uidx = upd_pc[INDEX_BITS+1:2];
  assign utag = upd_pc[31:INDEX_BITS+2];
  assign unused_bits = ^{current_pc[1:0], upd_pc[1:0]};

  assign hit       = valid[lidx] && (tag[lidx] == ltag);
  assign do_jcache = hit && ctr[lidx][1];
  assign jcache_pc = do_jcache ? target[lidx] : 32'b0;
  assign umatch    = valid[uidx] && (tag[uidx] == utag);

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= '0;
      end
    end else if (invalidate) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= '0;
    end else if (upd_valid) begin
      if (umatch) begin
        if (upd_taken) begin
          target[uidx] <= upd_target;
          if (ctr[uidx] != 2'b11) ctr[uidx] <= ctr[uidx] + 2'd1;
        end else if (ctr[uidx] != 2'b00) begin
          ctr[uidx] <= ctr[uidx] - 2'd1;
        end
      end else if (upd_taken) begin
        // A taken miss evicts whatever aliases into this slot.
        valid[uidx]  <= 1'b1;
        tag[uidx]    <= utag;
        target[uidx] <= upd_target;
        ctr[uidx]    <= 2'b10;
      end
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      stat_hits <= '0;
    end else if (do_jcache && stat_hits != 16'hFFFF) begin
      stat_hits <= stat_hits + 16'd1;
    end
  end

endmodule

// File: tb/tb_jump_cache.sv
// Bench for jump_cache: directed table, hand sequences, random vs model.
// Model keeps per-slot integers and applies the prediction rules directly.
module tb_jump_cache;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] current_pc;
  logic        do_jcache;
  logic [31:0] jcache_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        invalidate;
  logic [15:0] stat_hits;

  jump_cache dut (
    .clock(clock), .reset(reset), .current_pc(current_pc),
    .do_jcache(do_jcache), .jcache_pc(jcache_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .invalidate(invalidate),
    .stat_hits(stat_hits)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_hits;

  typedef struct {
    logic [31:0] cpc;
    bit          uv;
    logic [31:0] upc;
    bit          ut;
    logic [31:0] utg;
    bit          inv;
    bit          exp_do;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic int unsigned tagof(input logic [31:0] pc);
    return pc / 64;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
    end
    m_hits = 0;
  endfunction

  function automatic void m_look(input logic [31:0] pc, output bit d,
                                 output logic [31:0] t);
    int s = slot(pc);
    bit h = m_valid[s] && m_tag[s] == tagof(pc);
    d = h && m_ctr[s] >= 2;
    t = d ? m_tgt[s] : 32'h0;
  endfunction

  function automatic void m_edge(input bit d);
    int s = slot(upd_pc);
    if (d) m_hits = (m_hits + 1 > 65535) ? 65535 : m_hits + 1;
    if (invalidate) begin
      for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_ctr[i] = 0; end
    end else if (upd_valid) begin
      if (m_valid[s] && m_tag[s] == tagof(upd_pc)) begin
        if (upd_taken) begin
          m_tgt[s] = upd_target;
          m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
        end else begin
          m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (upd_taken) begin
        m_valid[s] = 1; m_tag[s] = tagof(upd_pc);
        m_tgt[s] = upd_target; m_ctr[s] = 2;
      end
    end
  endfunction

  task automatic drive(input logic [31:0] cpc, input bit uv,
                       input logic [31:0] upc, input bit ut,
                       input logic [31:0] utg, input bit inv);
    current_pc = cpc; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_target = utg; invalidate = inv;
  endtask

  task automatic settle(input bit chk);
    bit d;
    logic [31:0] t;
    #1;
    m_look(current_pc, d, t);
    if (chk) begin
      check("model_do", {31'b0, do_jcache}, {31'b0, d});
      check("model_pc", jcache_pc, t);
      check("model_hits", {16'b0, stat_hits}, m_hits);
    end
  endtask

  task automatic edge_step();
    bit d;
    logic [31:0] t;
    m_look(current_pc, d, t);
    @(negedge clock);
    m_edge(d);
    #1;
  endtask

  task automatic cyc(input logic [31:0] cpc, input bit uv,
                     input logic [31:0] upc, input bit ut,
                     input logic [31:0] utg, input bit inv, input bit chk);
    drive(cpc, uv, upc, ut, utg, inv);
    settle(chk);
    edge_step();
  endtask

  task automatic add(input logic [31:0] cpc, input bit uv,
                     input logic [31:0] upc, input bit ut,
                     input logic [31:0] utg, input bit inv,
                     input bit ed, input logic [31:0] ep);
    vec_t v;
    v.cpc = cpc; v.uv = uv; v.upc = upc; v.ut = ut;
    v.utg = utg; v.inv = inv; v.exp_do = ed; v.exp_pc = ep;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] tags [3];
    logic [31:0] pc;
    tags[0] = 32'h4; tags[1] = 32'h5; tags[2] = 32'h3FF_FFFF;

    add(32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 32'h0);
    add(32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 32'h200);
    add(32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 32'h200);
    add(32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 32'h200);
    add(32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 32'h0);
    add(32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 32'h200);
    add(32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 32'h200);
    add(32'h100, 0, 32'h0,   0, 32'h0,   0, 1, 32'h200);
    add(32'h140, 1, 32'h140, 1, 32'h300, 0, 0, 32'h0);
    add(32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0);
    add(32'h140, 0, 32'h0,   0, 32'h0,   0, 1, 32'h300);
    add(32'h140, 1, 32'h180, 1, 32'h500, 1, 1, 32'h300);
    add(32'h180, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0);
    add(32'h140, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0);
    add(32'h100, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0);

    reset = 1'b1;
    drive(32'h100, 0, 0, 0, 0, 0);
    m_reset();
    #2;
    check("rst_do", {31'b0, do_jcache}, 32'h0);
    check("rst_pc", jcache_pc, 32'h0);
    check("rst_hits", {16'b0, stat_hits}, 32'h0);
    #5 reset = 1'b0;
    @(negedge clock); #1;

    foreach (tbl[i]) begin
      drive(tbl[i].cpc, tbl[i].uv, tbl[i].upc, tbl[i].ut,
            tbl[i].utg, tbl[i].inv);
      settle(1);
      check($sformatf("tbl%0d_do", i), {31'b0, do_jcache},
            {31'b0, tbl[i].exp_do});
      check($sformatf("tbl%0d_pc", i), jcache_pc, tbl[i].exp_pc);
      edge_step();
    end
    check("inv_keeps_hits", {16'b0, stat_hits}, 32'd8);

    // Same-cycle lookup and retarget: old target now, new target after edge.
    cyc(32'h100, 1, 32'h100, 1, 32'h200, 0, 1);
    drive(32'h100, 1, 32'h100, 1, 32'h400, 0);
    settle(1);
    check("rw_old", jcache_pc, 32'h200);
    edge_step();
    drive(32'h100, 0, 0, 0, 0, 0);
    settle(1);
    check("rw_new", jcache_pc, 32'h400);
    edge_step();

    // Async reset arriving in the middle of an update cycle.
    drive(32'h100, 1, 32'h100, 1, 32'h999, 0);
    #3 reset = 1'b1;
    #1;
    m_reset();
    check("midrst_do", {31'b0, do_jcache}, 32'h0);
    check("midrst_pc", jcache_pc, 32'h0);
    check("midrst_hits", {16'b0, stat_hits}, 32'h0);
    drive(32'h100, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    @(negedge clock); #1;
    cyc(32'h100, 0, 0, 0, 0, 0, 1);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] c, u;
      c = (tags[$urandom_range(2)] << 6) | ($urandom_range(15) << 2)
          | $urandom_range(3);
      u = (tags[$urandom_range(2)] << 6) | ($urandom_range(15) << 2)
          | $urandom_range(3);
      if ($urandom_range(1)) c = u;
      cyc(c, $urandom_range(1), u, $urandom_range(9) < 7,
          $urandom & 32'hFFFF_FFFC, $urandom_range(99) == 0, 1);
    end

    // Saturation of the hit counter.
    pc = 32'h100;
    cyc(pc, 1, pc, 1, 32'h800, 0, 1);
    for (int n = 0; n < 65540; n++) cyc(pc, 0, 0, 0, 0, 0, n % 4096 == 0);
    settle(1);
    check("sat_hits", {16'b0, stat_hits}, 32'hFFFF);
    check("sat_pc", jcache_pc, 32'h800);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
